adder_bist_driver: RTL and testbench
====================================

// Module: adder_bist_driver
// PURPOSE
//  Hardware stimulus/checker for the combinational BrentKungAdder; the driving and checking end of its A/B/C_0 -> S/C_out interface.
//  Drives registered operand vectors (two fixed directed vectors, then LFSR vectors) and waits a settle time.
//  Samples {C_out,S} and compares it with an internal golden a+b+c_in. Counts mismatches and records the first failure.
//  Sits between a test controller (start/done) and one adder instance, for on-chip self-test of adder variants.
// PARAMETERS
//  WIDTH          8        operand width; adder bits 1..WIDTH
//  NUM_VECTORS    256      vectors per run, >=2; includes the 2 directed vectors
//  SETTLE_CYCLES  2        wait cycles between driving operands and sampling the result, >=1
//  LFSR_SEED      16'hACE1 LFSR value loaded on start; must be nonzero
//  ERR_W          16       error counter width
// PORTS
//  clk           in   1          rising-edge clock
//  rst           in   1          synchronous, active-high reset
//  start         in   1          run request; sampled only in IDLE or DONE
//  a_out         out  WIDTH      to adder A_1..A_WIDTH (a_out[0]=A_1)
//  b_out         out  WIDTH      to adder B_1..B_WIDTH
//  c_in_out      out  1          to adder C_0
//  s_in          in   WIDTH      from adder S_1..S_WIDTH
//  c_out_in      in   1          from adder C_out
//  busy          out  1          high in LOAD/SETTLE/CHECK
//  done          out  1          high while in DONE
//  pass          out  1          done && err_count==0
//  err_count     out  ERR_W      mismatches this run, saturating
//  fail_valid    out  1          a failure has been captured this run
//  fail_idx      out  16         vector index of the first failure
//  fail_a/fail_b out  WIDTH      operands of the first failure
//  fail_cin      out  1          carry-in of the first failure
//  fail_obs      out  WIDTH+1    observed {c_out,s} of the first failure
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; vector index=0; settle counter=0; lfsr=LFSR_SEED.
//  FSM: IDLE -start-> LOAD -> SETTLE (SETTLE_CYCLES cycles) -> CHECK -> LOAD (index advances) | DONE after the last index.
//   DONE -start-> LOAD. No other transitions.
//  On start: clear err_count and all fail_* outputs, index=0, lfsr=LFSR_SEED.
//  LOAD (1 cycle) registers the vector for the current index onto a_out/b_out/c_in_out.
//   idx0: a=0x03, b=0x01, cin=0.
//   idx1: a=0x85, b=0x8C, cin=0.
//   idx>=2: a=lfsr[WIDTH-1:0], b=lfsr[2*WIDTH-1:WIDTH] (mod 16), cin=lfsr[15].
//  Operands hold stable from LOAD through CHECK.
//  LFSR: Fibonacci x^16+x^14+x^13+x^11+1. Steps once at each CHECK where idx>=2.
//  CHECK (1 cycle): golden = a + b + cin, computed WIDTH+1 bits wide with no truncation. Mismatch if {c_out_in,s_in} != golden.
//   On mismatch, err_count increments and saturates at 2^ERR_W-1.
//   On the first mismatch of a run, fail_* are captured and fail_valid is set.
//  Per-vector cost is SETTLE_CYCLES+2 cycles. done rises exactly NUM_VECTORS*(SETTLE_CYCLES+2) cycles after the start-sampling edge.
//  done/pass/err_count/fail_* hold in DONE until the next start or rst.
//  start while busy: ignored; no restart, no effect on counters.
//  rst mid-run: returns to IDLE next edge; all outputs 0; partial results discarded.
//  a_out/b_out/c_in_out keep their last values in DONE; they are 0 only after reset.
// TESTING
//  1) Correct adder model, defaults, pulse start -> done at cycle 1024, err_count=0, pass=1, fail_valid=0.
//  2) Adder with C_out stuck 0 -> fail_valid=1, fail_idx=1, fail_a=0x85, fail_b=0x8C, fail_obs=0x011 (exp 0x111); pass=0.
//  3) NUM_VECTORS=2, correct adder -> done after 8 cycles; vectors exactly (0x03,0x01,0) then (0x85,0x8C,0).
//  4) ERR_W=4, adder output inverted, 256 vectors -> err_count saturates at 15, pass=0, fail_idx=0.
//  5) start re-pulsed while busy at vector 10 -> run unaffected, done still at cycle 1024.
//  6) rst at vector 50 -> all outputs 0 next cycle; a new start gives results identical to scenario 1.

Source files
------------

// File: rtl/adder_bist_driver.sv
// Self-test driver/checker for a combinational adder: drives directed then LFSR operand
// vectors, waits a settle time, and compares {c_out,s} against an internal a+b+c_in.
module adder_bist_driver #(
    parameter int          WIDTH         = 8,
    parameter int          NUM_VECTORS   = 256,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int          ERR_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    output logic               c_in_out,
    input  logic [WIDTH-1:0]   s_in,
    input  logic               c_out_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic               fail_valid,
    output logic [15:0]        fail_idx,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b,
    output logic               fail_cin,
    output logic [WIDTH:0]     fail_obs
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [15:0]      LAST_IDX    = 16'(NUM_VECTORS - 1);
    localparam logic [15:0]      SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    state_t             state_r;
    logic [15:0]        idx_r;
    logic [15:0]        settle_cnt_r;
    logic [15:0]        lfsr_r;
    logic [WIDTH-1:0]   vec_a_s;
    logic [WIDTH-1:0]   vec_b_s;
    logic               vec_cin_s;
    logic [WIDTH:0]     golden_s;
    logic [WIDTH:0]     obs_s;
    logic               mismatch_s;
    logic [ERR_W-1:0]   err_next_s;

    // Fibonacci LFSR for x^16+x^14+x^13+x^11+1, shifting toward bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        logic fb;
        fb = cur[0] ^ cur[2] ^ cur[3] ^ cur[5];
        return {fb, cur[15:1]};
    endfunction

    // Operand vector for the current index: two directed vectors, then LFSR slices.
    always_comb begin
        vec_a_s   = '0;
        vec_b_s   = '0;
        vec_cin_s = 1'b0;
        case (idx_r)
            16'd0: begin
                vec_a_s   = WIDTH'(8'h03);
                vec_b_s   = WIDTH'(8'h01);
                vec_cin_s = 1'b0;
            end
            16'd1: begin
                vec_a_s   = WIDTH'(8'h85);
                vec_b_s   = WIDTH'(8'h8C);
                vec_cin_s = 1'b0;
            end
            default: begin
                for (int i = 0; i < WIDTH; i++) begin
                    vec_a_s[i] = lfsr_r[4'(i % 16)];
                    vec_b_s[i] = lfsr_r[4'((WIDTH + i) % 16)];
                end
                vec_cin_s = lfsr_r[15];
            end
        endcase
    end

    // Golden sum is one bit wider than the operands so the carry is never lost.
    always_comb begin
        golden_s   = {1'b0, a_out} + {1'b0, b_out} + {{WIDTH{1'b0}}, c_in_out};
        obs_s      = {c_out_in, s_in};
        mismatch_s = (obs_s != golden_s);
    end

    // Saturating error count as it will be after the current cycle.
    always_comb begin
        err_next_s = err_count;
        if ((state_r == ST_CHECK) && mismatch_s && (err_count != ERR_MAX)) begin
            err_next_s = err_count + ERR_W'(1);
        end else begin
            err_next_s = err_count;
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= 16'd0;
            settle_cnt_r <= 16'd0;
            lfsr_r       <= LFSR_SEED;
            a_out        <= '0;
            b_out        <= '0;
            c_in_out     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_valid   <= 1'b0;
            fail_idx     <= 16'd0;
            fail_a       <= '0;
            fail_b       <= '0;
            fail_cin     <= 1'b0;
            fail_obs     <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r    <= ST_LOAD;
                        idx_r      <= 16'd0;
                        lfsr_r     <= LFSR_SEED;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_idx   <= 16'd0;
                        fail_a     <= '0;
                        fail_b     <= '0;
                        fail_cin   <= 1'b0;
                        fail_obs   <= '0;
                    end
                end
                ST_LOAD: begin
                    a_out        <= vec_a_s;
                    b_out        <= vec_b_s;
                    c_in_out     <= vec_cin_s;
                    settle_cnt_r <= 16'd0;
                    state_r      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt_r == SETTLE_LAST) begin
                        settle_cnt_r <= 16'd0;
                        state_r      <= ST_CHECK;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + 16'd1;
                    end
                end
                ST_CHECK: begin
                    err_count <= err_next_s;
                    if (mismatch_s && !fail_valid) begin
                        fail_valid <= 1'b1;
                        fail_idx   <= idx_r;
                        fail_a     <= a_out;
                        fail_b     <= b_out;
                        fail_cin   <= c_in_out;
                        fail_obs   <= obs_s;
                    end
                    if (idx_r >= 16'd2) begin
                        lfsr_r <= lfsr_step(lfsr_r);
                    end
                    if (idx_r == LAST_IDX) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (err_next_s == '0);
                    end else begin
                        idx_r   <= idx_r + 16'd1;
                        state_r <= ST_LOAD;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    pass    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bist_driver.sv
// Bench for adder_bist_driver: behavioural adders with injectable faults and a
// vector-list reference model predicting error counts and the first captured failure.
module tb_adder_bist_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Main instance (defaults)
    logic       start;
    logic [7:0] a_out, b_out, s_in, fail_a, fail_b;
    logic       c_in_out, c_out_in, busy, done, pass, fail_valid, fail_cin;
    logic [15:0] err_count, fail_idx;
    logic [8:0] fail_obs;
    int         fault_mode;
    logic [2:0] fault_key;
    logic [8:0] fault_mask;

    // Two-vector instance, correct adder
    logic       start_n2;
    logic [7:0] a_n2, b_n2, s_n2, fa_n2, fb_n2;
    logic       ci_n2, co_n2, busy_n2, done_n2, pass_n2, fv_n2, fc_n2;
    logic [15:0] err_n2, fidx_n2;
    logic [8:0] fobs_n2;

    // Narrow error counter instance, inverted adder
    logic       start_e4;
    logic [7:0] a_e4, b_e4, s_e4, fa_e4, fb_e4;
    logic       ci_e4, co_e4, busy_e4, done_e4, pass_e4, fv_e4, fc_e4;
    logic [3:0] err_e4;
    logic [15:0] fidx_e4;
    logic [8:0] fobs_e4;

    // Adder behaviour with fault modes: 0 ok, 1 carry stuck 0, 2 inverted, 3 keyed corruption
    function automatic logic [8:0] adder_model(input logic [7:0] a, input logic [7:0] b,
                                               input logic c, input int mode,
                                               input logic [2:0] key, input logic [8:0] mask);
        logic [8:0] r;
        r = 9'(int'(a) + int'(b) + int'(c));
        case (mode)
            1: r[8] = 1'b0;
            2: r = ~r;
            3: if (a[2:0] == key) r = r ^ mask;
            default: ;
        endcase
        return r;
    endfunction

    assign {c_out_in, s_in} = adder_model(a_out, b_out, c_in_out, fault_mode, fault_key, fault_mask);
    assign {co_n2, s_n2}    = adder_model(a_n2, b_n2, ci_n2, 0, 3'd0, 9'd0);
    assign {co_e4, s_e4}    = adder_model(a_e4, b_e4, ci_e4, 2, 3'd0, 9'd0);

    adder_bist_driver dut (
        .clk(clk), .rst(rst), .start(start), .a_out(a_out), .b_out(b_out), .c_in_out(c_in_out),
        .s_in(s_in), .c_out_in(c_out_in), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_valid(fail_valid), .fail_idx(fail_idx), .fail_a(fail_a),
        .fail_b(fail_b), .fail_cin(fail_cin), .fail_obs(fail_obs)
    );

    adder_bist_driver #(.NUM_VECTORS(2)) dut_n2 (
        .clk(clk), .rst(rst), .start(start_n2), .a_out(a_n2), .b_out(b_n2), .c_in_out(ci_n2),
        .s_in(s_n2), .c_out_in(co_n2), .busy(busy_n2), .done(done_n2), .pass(pass_n2),
        .err_count(err_n2), .fail_valid(fv_n2), .fail_idx(fidx_n2), .fail_a(fa_n2),
        .fail_b(fb_n2), .fail_cin(fc_n2), .fail_obs(fobs_n2)
    );

    adder_bist_driver #(.ERR_W(4)) dut_e4 (
        .clk(clk), .rst(rst), .start(start_e4), .a_out(a_e4), .b_out(b_e4), .c_in_out(ci_e4),
        .s_in(s_e4), .c_out_in(co_e4), .busy(busy_e4), .done(done_e4), .pass(pass_e4),
        .err_count(err_e4), .fail_valid(fv_e4), .fail_idx(fidx_e4), .fail_a(fa_e4),
        .fail_b(fb_e4), .fail_cin(fc_e4), .fail_obs(fobs_e4)
    );

    // Reference vector list and expected outcome of a run
    logic [7:0] ref_a [256];
    logic [7:0] ref_b [256];
    logic       ref_c [256];
    int         exp_err, exp_fidx;
    logic       exp_fv, exp_fc;
    logic [7:0] exp_fa, exp_fb;
    logic [8:0] exp_fobs;

    task automatic build_vectors;
        int lfsr;
        int fb;
        lfsr = 'hACE1;
        for (int i = 0; i < 256; i++) begin
            if (i == 0) begin
                ref_a[i] = 8'h03; ref_b[i] = 8'h01; ref_c[i] = 1'b0;
            end else if (i == 1) begin
                ref_a[i] = 8'h85; ref_b[i] = 8'h8C; ref_c[i] = 1'b0;
            end else begin
                ref_a[i] = 8'(lfsr % 256);
                ref_b[i] = 8'((lfsr / 256) % 256);
                ref_c[i] = 1'((lfsr / 32768) % 2);
                fb   = (lfsr ^ (lfsr >> 2) ^ (lfsr >> 3) ^ (lfsr >> 5)) & 1;
                lfsr = (lfsr >> 1) | (fb << 15);
            end
        end
    endtask

    task automatic model_run(input int mode, input int nvec, input int errw);
        int cnt;
        int lim;
        logic [8:0] golden, obs;
        cnt = 0; exp_fv = 1'b0; exp_fidx = 0; exp_fa = 8'd0; exp_fb = 8'd0;
        exp_fc = 1'b0; exp_fobs = 9'd0;
        for (int i = 0; i < nvec; i++) begin
            golden = 9'(int'(ref_a[i]) + int'(ref_b[i]) + int'(ref_c[i]));
            obs    = adder_model(ref_a[i], ref_b[i], ref_c[i], mode, fault_key, fault_mask);
            if (obs != golden) begin
                if (cnt == 0) begin
                    exp_fv = 1'b1; exp_fidx = i; exp_fa = ref_a[i]; exp_fb = ref_b[i];
                    exp_fc = ref_c[i]; exp_fobs = obs;
                end
                cnt++;
            end
        end
        lim = (1 << errw) - 1;
        exp_err = (cnt > lim) ? lim : cnt;
    endtask

    // Pulses start on the main instance and waits for done (optional re-pulse / reset)
    task automatic run_main(input int repulse_at, input int rst_at, output int cycles);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        cycles = 0;
        while (done !== 1'b1 && cycles < 1100) begin
            @(posedge clk); #1;
            cycles++;
            start = (cycles == repulse_at);
            if (cycles == rst_at) begin
                start = 1'b0;
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; start_n2 = 1'b0; start_e4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_out, b_out, c_in_out, busy, done, pass, err_count, fail_valid, fail_idx,
             fail_a, fail_b, fail_cin, fail_obs} !== '0) begin
            errors++; $display("FAIL reset_outputs got a=%h b=%h busy=%b done=%b err=%0d fv=%b expected all 0",
                               a_out, b_out, busy, done, err_count, fail_valid);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_correct;
        int cyc;
        fault_mode = 0;
        model_run(0, 256, 16);
        run_main(0, 0, cyc);
        checks++; if (cyc !== 1024) begin errors++; $display("FAIL correct_done_cycle got %0d expected 1024", cyc); end
        checks++; if (err_count !== 16'(exp_err)) begin errors++; $display("FAIL correct_err got %0d expected %0d", err_count, exp_err); end
        checks++; if (pass !== 1'b1 || fail_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL correct_flags got pass=%b fv=%b busy=%b expected 1 0 0", pass, fail_valid, busy); end
        checks++; if ({a_out, b_out, c_in_out} !== {ref_a[255], ref_b[255], ref_c[255]}) begin
            errors++; $display("FAIL correct_last_vector got %h %h %b expected %h %h %b",
                               a_out, b_out, c_in_out, ref_a[255], ref_b[255], ref_c[255]); end
        // Results must hold in DONE
        repeat (5) @(posedge clk);
        #1;
        checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL correct_hold got done=%b pass=%b expected 1 1", done, pass); end
    endtask

    task automatic test_cout_stuck;
        int cyc;
        fault_mode = 1;
        model_run(1, 256, 16);
        run_main(0, 0, cyc);
        checks++; if (cyc !== 1024) begin errors++; $display("FAIL stuck_done_cycle got %0d expected 1024", cyc); end
        checks++; if (fail_valid !== 1'b1 || fail_idx !== 16'd1 || fail_a !== 8'h85 || fail_b !== 8'h8C || fail_cin !== 1'b0) begin
            errors++; $display("FAIL stuck_capture got fv=%b idx=%0d a=%h b=%h cin=%b expected 1 1 85 8c 0",
                               fail_valid, fail_idx, fail_a, fail_b, fail_cin); end
        checks++; if (fail_obs !== 9'h011) begin errors++; $display("FAIL stuck_obs got %h expected 011", fail_obs); end
        checks++; if (err_count !== 16'(exp_err) || pass !== 1'b0) begin
            errors++; $display("FAIL stuck_err got err=%0d pass=%b expected %0d 0", err_count, pass, exp_err); end
    endtask

    task automatic test_vectors_n2;
        int cyc;
        logic [16:0] v0, v1;
        v0 = '0; v1 = '0;
        @(negedge clk); start_n2 = 1'b1;
        @(posedge clk); #1; start_n2 = 1'b0;
        cyc = 0;
        checks++; if (busy_n2 !== 1'b1 || done_n2 !== 1'b0) begin errors++; $display("FAIL n2_busy got busy=%b done=%b expected 1 0", busy_n2, done_n2); end
        while (done_n2 !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) v0 = {a_n2, b_n2, ci_n2};
            if (cyc == 5) v1 = {a_n2, b_n2, ci_n2};
        end
        checks++; if (cyc !== 8) begin errors++; $display("FAIL n2_done_cycle got %0d expected 8", cyc); end
        checks++; if (v0 !== {8'h03, 8'h01, 1'b0}) begin errors++; $display("FAIL n2_vec0 got %h expected %h", v0, {8'h03, 8'h01, 1'b0}); end
        checks++; if (v1 !== {8'h85, 8'h8C, 1'b0}) begin errors++; $display("FAIL n2_vec1 got %h expected %h", v1, {8'h85, 8'h8C, 1'b0}); end
        checks++; if (err_n2 !== 16'd0 || pass_n2 !== 1'b1 || fv_n2 !== 1'b0) begin
            errors++; $display("FAIL n2_result got err=%0d pass=%b fv=%b expected 0 1 0", err_n2, pass_n2, fv_n2); end
    endtask

    task automatic test_saturate;
        int cyc;
        model_run(2, 256, 4);
        @(negedge clk); start_e4 = 1'b1;
        @(posedge clk); #1; start_e4 = 1'b0;
        cyc = 0;
        while (done_e4 !== 1'b1 && cyc < 1100) begin @(posedge clk); #1; cyc++; end
        checks++; if (cyc !== 1024) begin errors++; $display("FAIL sat_done_cycle got %0d expected 1024", cyc); end
        checks++; if (err_e4 !== 4'd15 || 4'(exp_err) !== err_e4) begin errors++; $display("FAIL sat_err got %0d expected 15", err_e4); end
        checks++; if (pass_e4 !== 1'b0 || fidx_e4 !== 16'd0 || fobs_e4 !== exp_fobs) begin
            errors++; $display("FAIL sat_capture got pass=%b idx=%0d obs=%h expected 0 0 %h", pass_e4, fidx_e4, fobs_e4, exp_fobs); end
    endtask

    task automatic test_busy_restart;
        int cyc;
        int rp;
        fault_mode = 0;
        model_run(0, 256, 16);
        rp = 40 + int'($urandom_range(0, 3));
        run_main(rp, 0, cyc);
        checks++; if (cyc !== 1024) begin errors++; $display("FAIL restart_done_cycle got %0d expected 1024 (repulse at %0d)", cyc, rp); end
        checks++; if (err_count !== 16'd0 || pass !== 1'b1 || fail_valid !== 1'b0) begin
            errors++; $display("FAIL restart_result got err=%0d pass=%b fv=%b expected 0 1 0", err_count, pass, fail_valid); end
    endtask

    task automatic test_rst_midrun;
        int cyc;
        int rc;
        fault_mode = 1;
        rc = 200 + int'($urandom_range(0, 3));
        run_main(0, rc, cyc);
        checks++;
        if ({a_out, b_out, c_in_out, busy, done, pass, err_count, fail_valid, fail_idx,
             fail_a, fail_b, fail_cin, fail_obs} !== '0) begin
            errors++; $display("FAIL rst_mid_outputs got a=%h b=%h busy=%b err=%0d fv=%b expected all 0",
                               a_out, b_out, busy, err_count, fail_valid);
        end
        fault_mode = 0;
        model_run(0, 256, 16);
        run_main(0, 0, cyc);
        checks++; if (cyc !== 1024) begin errors++; $display("FAIL rst_rerun_cycle got %0d expected 1024", cyc); end
        checks++; if (err_count !== 16'(exp_err) || pass !== 1'b1 || fail_valid !== 1'b0) begin
            errors++; $display("FAIL rst_rerun_result got err=%0d pass=%b fv=%b expected %0d 1 0", err_count, pass, fail_valid, exp_err); end
    endtask

    task automatic test_random_fault;
        int cyc;
        for (int k = 0; k < 3; k++) begin
            fault_mode = 3;
            fault_key  = 3'($urandom_range(0, 7));
            fault_mask = 9'($urandom_range(1, 511));
            model_run(3, 256, 16);
            run_main(0, 0, cyc);
            checks++; if (err_count !== 16'(exp_err) || pass !== (exp_err == 0)) begin
                errors++; $display("FAIL rand_err key=%0d mask=%h got err=%0d pass=%b expected %0d", fault_key, fault_mask, err_count, pass, exp_err); end
            checks++; if ({fail_valid, fail_idx, fail_a, fail_b, fail_cin, fail_obs} !==
                          {exp_fv, 16'(exp_fidx), exp_fa, exp_fb, exp_fc, exp_fobs}) begin
                errors++; $display("FAIL rand_capture got fv=%b idx=%0d a=%h b=%h cin=%b obs=%h expected %b %0d %h %h %b %h",
                                   fail_valid, fail_idx, fail_a, fail_b, fail_cin, fail_obs,
                                   exp_fv, exp_fidx, exp_fa, exp_fb, exp_fc, exp_fobs); end
        end
    endtask

    initial begin
        fault_mode = 0; fault_key = 3'd0; fault_mask = 9'd0;
        rst = 1'b1; start = 1'b0; start_n2 = 1'b0; start_e4 = 1'b0;
        build_vectors();
        test_reset();
        test_correct();
        test_cout_stuck();
        test_vectors_n2();
        test_saturate();
        test_busy_restart();
        test_rst_midrun();
        test_random_fault();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
